// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: parity modes, frame state encoding
// and the clocks-per-bit helper used by transmitter and receiver.
package serial_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } serial_state_t;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/serial_baud_counter.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and flags the last cycle of each
// bit period; held at zero while clear is asserted.
module serial_baud_counter #(
    parameter int BIT_CYCLES = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
        $error("serial_baud_counter: BIT_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == LAST) && !clear;

endmodule

// File: rtl/serial_transmitter.sv
// UART-style transmitter: start bit, NUM_BITS data bits LSB first, optional
// parity bit, STOP_BITS stop bits; one word accepted per valid/ready handshake.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int PARITY    = 0,
    parameter int NUM_BITS  = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] data,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                tx,
    output logic                tx_done
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int BIT_IDX_W  = $clog2(NUM_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(NUM_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic PAR_INV   = (PARITY == PARITY_ODD);
    localparam bit   HAS_PAR   = (PARITY != PARITY_NONE);

    if ((PARITY != PARITY_NONE) && (PARITY != PARITY_ODD) && (PARITY != PARITY_EVEN)) begin : g_bad_parity
        $error("serial_transmitter: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if ((NUM_BITS < 5) || (NUM_BITS > 9)) begin : g_bad_num_bits
        $error("serial_transmitter: NUM_BITS must be in 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("serial_transmitter: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYCLES < 1) begin : g_bad_baud
        $error("serial_transmitter: CLK_FREQ must be at least BAUD_RATE");
    end

    serial_state_t          state;
    logic [NUM_BITS-1:0]    shreg;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic                   stop_idx;
    logic                   par_acc;
    logic                   bit_end;
    logic                   baud_clear;

    assign baud_clear = (state == ST_IDLE);

    serial_baud_counter #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (baud_clear),
        .bit_end(bit_end)
    );

    // tx is loaded with the value of the upcoming bit on each transition so
    // the pin stays a pure flop output; parity accumulates over the bits as
    // they leave the latched shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_acc    <= 1'b0;
            tx         <= 1'b1;
            data_ready <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx         <= 1'b1;
                    data_ready <= 1'b1;
                    if (data_valid && data_ready) begin
                        shreg      <= data;
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                        par_acc    <= 1'b0;
                        tx         <= 1'b0;
                        data_ready <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        par_acc <= par_acc ^ shreg[0];
                        shreg   <= shreg >> 1;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (HAS_PAR) begin
                                tx    <= par_acc ^ shreg[0] ^ PAR_INV;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (stop_idx == LAST_STOP) begin
                            stop_idx   <= 1'b0;
                            data_ready <= 1'b1;
                            tx_done    <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx         <= 1'b1;
                    data_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Scoreboard bench: four transmitter configurations, stimulus pushes hand-computed
// frames, per-DUT monitors decode tx cycle by cycle and compare.
module tb_serial_transmitter;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BC       = 10;
    localparam int NB       = 8;

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         gap;
    } exp_t;

    logic       clk;
    logic       rst_a;
    logic       rst_o;
    logic [3:0] rst_v;
    logic [3:0] valid_v;
    logic [7:0] data_v [4];
    logic       tx0, tx1, tx2, tx3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       dn0, dn1, dn2, dn3;
    logic [3:0] tx_v, ready_v, done_v;

    int n_cmp;
    int n_bad;
    int cyc;
    int done_cnt [4];
    exp_t q0[$], q1[$], q2[$], q3[$];

    assign rst_v   = {rst_o, rst_o, rst_o, rst_a};
    assign tx_v    = {tx3, tx2, tx1, tx0};
    assign ready_v = {rdy3, rdy2, rdy1, rdy0};
    assign done_v  = {dn3, dn2, dn1, dn0};

    serial_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(0), .NUM_BITS(NB), .STOP_BITS(1))
        u_dut0 (.clk(clk), .rst_n(rst_a), .data(data_v[0]), .data_valid(valid_v[0]),
                .data_ready(rdy0), .tx(tx0), .tx_done(dn0));
    serial_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(1), .NUM_BITS(NB), .STOP_BITS(1))
        u_dut1 (.clk(clk), .rst_n(rst_o), .data(data_v[1]), .data_valid(valid_v[1]),
                .data_ready(rdy1), .tx(tx1), .tx_done(dn1));
    serial_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(2), .NUM_BITS(NB), .STOP_BITS(1))
        u_dut2 (.clk(clk), .rst_n(rst_o), .data(data_v[2]), .data_valid(valid_v[2]),
                .data_ready(rdy2), .tx(tx2), .tx_done(dn2));
    serial_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(0), .NUM_BITS(NB), .STOP_BITS(2))
        u_dut3 (.clk(clk), .rst_n(rst_o), .data(data_v[3]), .data_valid(valid_v[3]),
                .data_ready(rdy3), .tx(tx3), .tx_done(dn3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done_v[k] === 1'b1) done_cnt[k] = done_cnt[k] + 1;
        end
    end

    function automatic int par_cfg(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int stp_cfg(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{d: 8'h00, p: 1'b0, gap: 0};
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // Decodes one DUT's line; start bit index 0 is the first negedge after the handshake edge.
    task automatic monitor(input int k);
        exp_t e;
        bit ok, ab;
        logic prev, want, pbit;
        logic [7:0] got;
        int last_start, nbits, bad_line, bad_busy;
        prev = 1'b1;
        last_start = -100000;
        forever begin
            @(negedge clk);
            if (!(rst_v[k] && prev && !tx_v[k])) begin
                prev = rst_v[k] ? tx_v[k] : 1'b1;
                continue;
            end
            nbits = 1 + NB + ((par_cfg(k) != 0) ? 1 : 0) + stp_cfg(k);
            pop_exp(k, e, ok);
            check($sformatf("frame_expected_dut%0d", k), 32'(ok), 32'd1);
            if (e.gap != 0)
                check($sformatf("start_gap_dut%0d", k), 32'(cyc - last_start), 32'(e.gap));
            last_start = cyc;
            ab = 1'b0; bad_line = 0; bad_busy = 0; got = '0; pbit = 1'b0;
            for (int b = 0; b < nbits && !ab; b++) begin
                for (int c = 0; c < BC; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (!rst_v[k]) begin ab = 1'b1; break; end
                    if (b == 0) want = 1'b0;
                    else if (b <= NB) want = e.d[b-1];
                    else if (b == NB + 1 && par_cfg(k) != 0) want = e.p;
                    else want = 1'b1;
                    if (tx_v[k] !== want) bad_line++;
                    if (ready_v[k] !== 1'b0 || done_v[k] !== 1'b0) bad_busy++;
                    if (c == BC / 2) begin
                        if (b >= 1 && b <= NB) got[b-1] = tx_v[k];
                        else if (b == NB + 1 && par_cfg(k) != 0) pbit = tx_v[k];
                    end
                end
            end
            if (ab) begin
                prev = 1'b1;
                continue;
            end
            check($sformatf("line_bad_cycles_dut%0d", k), 32'(bad_line), 32'd0);
            check($sformatf("busy_bad_cycles_dut%0d", k), 32'(bad_busy), 32'd0);
            check($sformatf("decoded_data_dut%0d", k), 32'(got), 32'(e.d));
            if (par_cfg(k) != 0)
                check($sformatf("parity_bit_dut%0d", k), 32'(pbit), 32'(e.p));
            @(negedge clk);
            check($sformatf("done_ready_idle_dut%0d", k), 32'({done_v[k], ready_v[k], tx_v[k]}), 32'b111);
            prev = tx_v[k];
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
    end

    task automatic send(input int k, input logic [7:0] d, input logic p);
        int n;
        n = 0;
        @(negedge clk);
        data_v[k]  = d;
        valid_v[k] = 1'b1;
        while (ready_v[k] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("send_ready_dut%0d", k), 32'(ready_v[k]), 32'd1);
        push_exp(k, '{d: d, p: p, gap: 0});
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
        check($sformatf("start_after_handshake_dut%0d", k), 32'({tx_v[k], ready_v[k]}), 32'b00);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_v[k] !== 1'b1 && n < 2000);
        check($sformatf("done_seen_dut%0d", k), 32'(done_v[k]), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp = 0; n_bad = 0; cyc = 0;
        for (int k = 0; k < 4; k++) begin
            done_cnt[k] = 0;
            data_v[k]   = 8'h00;
        end
        valid_v = '0;
        rst_a = 1'b0;
        rst_o = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("reset_outputs_dut%0d", k), 32'({tx_v[k], ready_v[k], done_v[k]}), 32'b110);
        rst_a = 1'b1;
        rst_o = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("post_reset_outputs_dut%0d", k), 32'({tx_v[k], ready_v[k], done_v[k]}), 32'b110);

        // DUT0: plain frame, data change mid-frame, reset inside bit 3, busy pulse
        send(0, 8'h55, 1'b0);
        wait_done(0);
        send(0, 8'h12, 1'b0);
        repeat (30) @(negedge clk);
        data_v[0] = 8'hFF;
        wait_done(0);
        send(0, 8'hC3, 1'b0);
        repeat (44) @(posedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        check("async_reset_outputs", 32'({tx_v[0], ready_v[0], done_v[0]}), 32'b110);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check("after_reset_release", 32'({tx_v[0], ready_v[0], done_v[0]}), 32'b110);
        send(0, 8'h81, 1'b0);
        wait_done(0);
        send(0, 8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        data_v[0]  = 8'h99;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        wait_done(0);

        // DUT1 odd / DUT2 even parity on 0x07 (three ones)
        send(1, 8'h07, 1'b0);
        wait_done(1);
        send(2, 8'h07, 1'b1);
        wait_done(2);

        // DUT3: two stop bits, valid held for back-to-back 0xA3 then 0x3C
        @(negedge clk);
        data_v[3]  = 8'hA3;
        valid_v[3] = 1'b1;
        push_exp(3, '{d: 8'hA3, p: 1'b0, gap: 0});
        @(posedge clk);
        #1;
        data_v[3] = 8'h3C;
        push_exp(3, '{d: 8'h3C, p: 1'b0, gap: 111});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready_v[3] !== 1'b1 && n < 300);
        check("b2b_ready_dut3", 32'(ready_v[3]), 32'd1);
        @(posedge clk);
        #1;
        valid_v[3] = 1'b0;
        wait_done(3);

        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("queue_drained_dut%0d", k), 32'(q_size(k)), 32'd0);
        check("done_count_dut0", 32'(done_cnt[0]), 32'd4);
        check("done_count_dut1", 32'(done_cnt[1]), 32'd1);
        check("done_count_dut2", 32'(done_cnt[2]), 32'd1);
        check("done_count_dut3", 32'(done_cnt[3]), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- UART-style transmitter; the transmit end of the serial link whose receive end is already in the design.
- Accepts one NUM_BITS word per valid/ready handshake and drives it on tx: start bit, data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Sits between the file/echo datapath and the board TX pin.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- PARITY, 0, 0 = none, 1 = odd, 2 = even; any other value is an elaboration error.
- NUM_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1..2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- data  input  NUM_BITS  word to send; sampled only on handshake.
- data_valid  input  1  data is presented.
- data_ready  output  1  transmitter can accept a word.
- tx  output  1  serial line; idle high.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Timing constant: BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division).
  - Each bit holds tx for exactly BIT_CYCLES clocks.
  - Delay counter width is $clog2(BIT_CYCLES); it counts 0..BIT_CYCLES-1.
- Reset (rst_n low, asynchronous): tx=1, data_ready=1, tx_done=0, state IDLE, all counters 0, shift register 0. This holds mid-frame: tx returns high immediately and the frame is abandoned.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, data_ready=1.
  - Handshake occurs on a rising clk edge with data_valid && data_ready. On that edge: latch data into the shift register, clear counters, go to START, data_ready goes 0.
- START: tx=0 for BIT_CYCLES, starting the cycle after the handshake; then go to DATA.
- DATA:
  - tx = shift register bit 0; shift right at the end of each bit period.
  - After NUM_BITS bit periods go to PARITY if PARITY != 0, else STOP.
- PARITY: tx = XOR of the latched data (even); its inverse (odd). Duration BIT_CYCLES.
- STOP:
  - tx=1 for STOP_BITS*BIT_CYCLES.
  - On the last cycle of the last stop bit, go to IDLE.
  - In the following cycle: data_ready=1 and tx_done=1 for exactly one cycle.
- Frame length: (1 + NUM_BITS + (PARITY!=0) + STOP_BITS)*BIT_CYCLES clocks, from the cycle after the handshake.
- Back-to-back: with data_valid held high, the next handshake occurs in the tx_done cycle. Successive start bits are separated by exactly one extra idle clock beyond the stop bits.
- data and data_valid are ignored while data_ready=0; changing data mid-frame has no effect.
- Outputs are registered; tx never glitches.
- Parity is computed on the latched copy, not on live data.

Decomposition:
- Package serial_pkg holds:
  - parity constants PARITY_NONE/ODD/EVEN;
  - the state enum typedef (shared with the receiver once refactored);
  - a function bit_cycles(clk_freq, baud) returning CLK_FREQ/BAUD_RATE.
- One natural sub-module: serial_baud_counter.
  - Inputs: clk, rst_n, clear.
  - Output: bit_end, a pulse on the last cycle of each bit period.
  - Reusable by the receiver.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BIT_CYCLES=10):
- Send 0x55, PARITY=0, STOP_BITS=1 -> tx: 10 clk low, then 1,0,1,0,1,0,1,0 at 10 clk each, then 10 clk high; tx_done pulse 101 clk after the handshake edge; data_ready low throughout the frame.
- Send 0x07 with PARITY=1 (odd) -> parity bit 0; with PARITY=2 (even) -> parity bit 1; frame is 110 clk.
- STOP_BITS=2, data_valid held high with 0xA3 then 0x3C -> second start bit begins exactly 111 clk after the first; decoded bytes are 0xA3 and 0x3C, checked by a loopback into serial_receiver.
- Change data from 0x12 to 0xFF during the DATA state -> transmitted frame still carries 0x12; no second handshake.
- Assert rst_n low in the middle of bit 3 -> tx=1 in the same cycle (asynchronous); data_ready=1 after release; the next send of 0x81 transmits correctly.
- data_valid pulsed for 1 cycle while busy -> ignored; no extra frame; tx_done pulses once.
